// File: rtl/worddemux4.sv
// Four-slot word demultiplexer: one producer stream routed by i_sel into four
// single-word holding registers, each drained by its own consumer handshake.
module worddemux4 (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [0:1]  i_sel,
   input  logic [0:15] i_data,
   input  logic        i_flush,
   output logic [0:15] o_data0,
   output logic [0:15] o_data1,
   output logic [0:15] o_data2,
   output logic [0:15] o_data3,
   output logic [0:3]  o_valid,
   input  logic [0:3]  i_ready,
   output logic [0:15] o_count
);

   logic [1:0]  sel_s;
   logic [3:0]  cons_ready_s;
   logic        ready_s;
   logic        accept_s;
   logic [3:0]  load_s;
   logic [3:0]  drain_s;
   logic [3:0]  valid_r;
   logic [15:0] data_r [4];
   logic [15:0] count_r;

   // Slot decode, producer handshake and per-slot load/drain qualifiers.
   always_comb begin
      sel_s    = {i_sel[0], i_sel[1]};
      cons_ready_s = 4'b0000;
      load_s   = 4'b0000;
      drain_s  = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         cons_ready_s[k] = i_ready[k];
      end
      ready_s  = (~valid_r[sel_s] | cons_ready_s[sel_s]) & ~i_flush;
      accept_s = i_valid & ready_s;
      for (int k = 0; k < 4; k++) begin
         load_s[k]  = accept_s & (sel_s == 2'(k));
         drain_s[k] = valid_r[k] & cons_ready_s[k];
      end
   end

   // Slot state and accept counter; data registers keep their last word after drain or flush.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         valid_r <= 4'b0000;
         count_r <= 16'h0000;
         for (int k = 0; k < 4; k++) begin
            data_r[k] <= 16'h0000;
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (i_flush) begin
               valid_r[k] <= 1'b0;
            end else if (load_s[k]) begin
               valid_r[k] <= 1'b1;
               data_r[k]  <= i_data;
            end else if (drain_s[k]) begin
               valid_r[k] <= 1'b0;
            end else begin
               valid_r[k] <= valid_r[k];
            end
         end
         if (accept_s) begin
            count_r <= count_r + 16'd1;
         end else begin
            count_r <= count_r;
         end
      end
   end

   // Output mapping onto the MSB-first port ranges.
   always_comb begin
      o_ready = ready_s;
      o_data0 = data_r[0];
      o_data1 = data_r[1];
      o_data2 = data_r[2];
      o_data3 = data_r[3];
      o_count = count_r;
      o_valid = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         o_valid[k] = valid_r[k];
      end
   end

endmodule
